// File: rtl/sevenseg_pkg.sv
// Shared constants and types for seven-segment capture and decode.
// Segment codes use the team's 8-bit segment ordering.
package sevenseg_pkg;

  localparam logic [7:0] SEG_0     = 8'hEB;
  localparam logic [7:0] SEG_1     = 8'h28;
  localparam logic [7:0] SEG_2     = 8'hB3;
  localparam logic [7:0] SEG_3     = 8'hBA;
  localparam logic [7:0] SEG_4     = 8'h78;
  localparam logic [7:0] SEG_5     = 8'hDA;
  localparam logic [7:0] SEG_6     = 8'hDB;
  localparam logic [7:0] SEG_7     = 8'hA8;
  localparam logic [7:0] SEG_8     = 8'hFB;
  localparam logic [7:0] SEG_9     = 8'hFA;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [3:0] BCD_BLANK = 4'hA;
  localparam logic [3:0] BCD_BAD   = 4'hF;

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    HELD
  } cap_state_e;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational segment-pattern to BCD lookup.
// A blank pattern decodes to BCD_BLANK; unknown patterns flag bad_o.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [7:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       bad_o
);

  always_comb begin
    bcd_o = BCD_BAD;
    bad_o = 1'b0;
    case (seg_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: bcd_o = BCD_BLANK;
      default: begin
        bcd_o = BCD_BAD;
        bad_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Captures stable multiplexed seven-segment digits, decodes them to BCD and
// presents each complete frame on a valid/ready output.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          seg,
  input  logic [NDIG-1:0]     dig_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*NDIG-1:0]   out_bcd,
  output logic                out_err,
  output logic                overflow
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);

  logic [7:0]        seg_q, prev_seg_q;
  logic [NDIG-1:0]   en_q, prev_en_q;
  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              capture;
  logic              en_onehot, pair_changed, frame_done;
  logic [3:0]        dec_bcd;
  logic              dec_bad;
  logic [3:0]        digit_q [NDIG];
  logic [NDIG-1:0]   seen_q, bad_q;
  logic [4*NDIG-1:0] digit_flat;
  logic              out_valid_q, out_err_q, overflow_q;
  logic [4*NDIG-1:0] out_bcd_q;

  sevenseg_decode u_decode (
    .seg_i (seg_q),
    .bcd_o (dec_bcd),
    .bad_o (dec_bad)
  );

  // prev_* holds last cycle's registered pair so stability is judged on seg_q/en_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q      <= '0;
      en_q       <= '0;
      prev_seg_q <= '0;
      prev_en_q  <= '0;
    end else begin
      seg_q      <= seg;
      en_q       <= dig_en;
      prev_seg_q <= seg_q;
      prev_en_q  <= en_q;
    end
  end

  assign en_onehot    = $onehot(en_q);
  assign pair_changed = (seg_q != prev_seg_q) || (en_q != prev_en_q);
  assign frame_done   = &seen_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = CNT_W'(1);
    capture = 1'b0;
    if (!en_onehot) begin
      state_d = WAIT;
      cnt_d   = '0;
    end else if ((state_q == HELD) && !pair_changed) begin
      state_d = HELD;
    end else begin
      if ((state_q == SETTLE) && !pair_changed) begin
        cnt_inc = cnt_q + CNT_W'(1);
      end
      if (cnt_inc == CNT_W'(STABLE_CYC)) begin
        capture = 1'b1;
        state_d = HELD;
        cnt_d   = '0;
      end else begin
        state_d = SETTLE;
        cnt_d   = cnt_inc;
      end
    end
  end

  // A capture on the completion edge starts the next frame rather than being lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q <= '0;
      bad_q  <= '0;
      for (int i = 0; i < NDIG; i++) digit_q[i] <= '0;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (capture && en_q[i]) begin
          digit_q[i] <= dec_bcd;
          seen_q[i]  <= 1'b1;
          bad_q[i]   <= dec_bad;
        end else if (frame_done) begin
          seen_q[i]  <= 1'b0;
          bad_q[i]   <= 1'b0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_flat
    assign digit_flat[4*gi +: 4] = digit_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_valid_q <= 1'b1;
        out_bcd_q   <= digit_flat;
        out_err_q   <= |bad_q;
      end else begin
        overflow_q  <= 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_err   = out_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed self-checking bench for sevenseg_capture with NDIG=4, STABLE_CYC=4.
module tb_sevenseg_capture;
  import sevenseg_pkg::*;

  localparam int NDIG = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        seg;
  logic [NDIG-1:0]   dig_en;
  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] out_bcd;
  logic              out_err;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;

  sevenseg_capture #(.NDIG(NDIG), .STABLE_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .dig_en    (dig_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input logic [NDIG-1:0] en, input logic [7:0] s, input int cycles);
    dig_en = en;
    seg    = s;
    tick(cycles);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; seg = '0; dig_en = '0; out_ready = 1'b0;
    tick(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bcd",   32'(out_bcd),   32'd0);
    check("rst_err",   32'(out_err),   32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    rst = 1'b0;
    tick(2);

    // Frame 3,1,4,1
    show(4'b0001, SEG_3, 6);
    show(4'b0010, SEG_1, 6);
    show(4'b0100, SEG_4, 6);
    show(4'b1000, SEG_1, 5);
    check("f1_valid_early", 32'(out_valid), 32'd0);
    tick(1);
    $display("frame1: valid=%0b bcd=%h err=%0b", out_valid, out_bcd, out_err);
    check("f1_valid", 32'(out_valid), 32'd1);
    check("f1_bcd",   32'(out_bcd),   32'h1413);
    check("f1_err",   32'(out_err),   32'd0);
    accept();
    check("f1_drop", 32'(out_valid), 32'd0);
    show('0, SEG_BLANK, 2);

    // Digit 0 unstable for 3 cycles then a stable 5
    show(4'b0001, SEG_3, 3);
    show(4'b0001, SEG_5, 4);
    show(4'b0010, SEG_7, 6);
    show(4'b0100, SEG_9, 6);
    show(4'b1000, SEG_0, 6);
    $display("frame2: valid=%0b bcd=%h err=%0b", out_valid, out_bcd, out_err);
    check("f2_valid", 32'(out_valid), 32'd1);
    check("f2_bcd",   32'(out_bcd),   32'h0975);
    check("f2_err",   32'(out_err),   32'd0);
    accept();
    show('0, SEG_BLANK, 2);

    // Two strobes at once never capture
    show(4'b0011, SEG_1, 10);
    $display("two-hot: state=%0d", dut.state_q);
    check("twohot_state", 32'(dut.state_q), 32'(WAIT));

    // Blank and invalid patterns
    show(4'b0010, SEG_BLANK, 6);
    show(4'b0100, 8'h55, 6);
    show(4'b1000, SEG_8, 6);
    check("f3_no_frame", 32'(out_valid), 32'd0);
    show(4'b0001, SEG_5, 6);
    $display("frame3: valid=%0b bcd=%h err=%0b", out_valid, out_bcd, out_err);
    check("f3_valid", 32'(out_valid), 32'd1);
    check("f3_bcd",   32'(out_bcd),   32'h8FA5);
    check("f3_err",   32'(out_err),   32'd1);
    accept();
    show('0, SEG_BLANK, 2);

    // Two frames with out_ready low: second is dropped
    show(4'b0001, SEG_2, 6);
    show(4'b0010, SEG_6, 6);
    show(4'b0100, SEG_8, 6);
    show(4'b1000, SEG_1, 6);
    check("f4_valid", 32'(out_valid), 32'd1);
    check("f4_bcd",   32'(out_bcd),   32'h1862);
    check("f4_ovf0",  32'(overflow),  32'd0);
    show(4'b0001, SEG_9, 6);
    show(4'b0010, SEG_9, 6);
    show(4'b0100, SEG_9, 6);
    show(4'b1000, SEG_9, 6);
    $display("frame4 held: valid=%0b bcd=%h ovf=%0b", out_valid, out_bcd, overflow);
    check("f4_hold_valid", 32'(out_valid), 32'd1);
    check("f4_hold_bcd",   32'(out_bcd),   32'h1862);
    check("f4_ovf1",       32'(overflow),  32'd1);
    accept();
    check("f4_drop",   32'(out_valid), 32'd0);
    check("f4_sticky", 32'(overflow),  32'd1);
    show('0, SEG_BLANK, 2);

    // Reset with a partial frame in progress
    show(4'b0001, SEG_4, 6);
    show(4'b0010, SEG_3, 6);
    show(4'b0100, SEG_2, 6);
    dig_en = '0; seg = '0; rst = 1'b1;
    tick(2);
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_bcd",   32'(out_bcd),   32'd0);
    check("rst2_err",   32'(out_err),   32'd0);
    check("rst2_ovf",   32'(overflow),  32'd0);
    rst = 1'b0;
    show(4'b1000, SEG_1, 6);
    check("f5_partial_gone", 32'(out_valid), 32'd0);
    show(4'b0001, SEG_4, 6);
    show(4'b0010, SEG_3, 6);
    show(4'b0100, SEG_2, 6);
    $display("frame5: valid=%0b bcd=%h err=%0b ovf=%0b", out_valid, out_bcd, out_err, overflow);
    check("f5_valid", 32'(out_valid), 32'd1);
    check("f5_bcd",   32'(out_bcd),   32'h1234);
    check("f5_err",   32'(out_err),   32'd0);
    check("f5_ovf",   32'(overflow),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

- Segment-pattern capture and decode block for multiplexed seven-segment display buses.
- It watches a display driver's segment lines and one-hot digit strobes, filters glitches, and decodes each stable pattern back to BCD.
- It assembles one complete multi-digit frame and presents it through a valid/ready output.
- It sits on the self-test and loopback path, checking what the display encoder actually drives.

## Interface
- NDIG, 4: number of multiplexed digits; 1..8.
- STABLE_CYC, 4: consecutive identical samples required before a capture; ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- seg  in  8  segment lines, team segment encoding.
- dig_en  in  NDIG  digit strobe; valid only when exactly one bit is set.
- out_valid  out  1  frame available; reset 0.
- out_ready  in  1  consumer accepts the frame when out_valid && out_ready.
- out_bcd  out  4*NDIG  decoded digits, digit i in bits [4i+3:4i]; reset 0.
- out_err  out  1  at least one digit in the frame was undecodable; reset 0.
- overflow  out  1  sticky: a frame was dropped; reset 0, cleared only by rst.

## Operation
- Inputs are registered once (seg_q, en_q) before any use.
- Decode map (seg → bcd):
  - 0xEB→0, 0x28→1, 0xB3→2, 0xBA→3, 0x78→4, 0xDA→5, 0xDB→6, 0xA8→7, 0xFB→8, 0xFA→9.
  - 0x00→4'hA (blank, not an error).
  - Any other pattern → 4'hF and sets that digit's bad bit.
- Capture FSM:
  - WAIT: en_q is not one-hot. Stable counter = 0.
  - SETTLE: en_q is one-hot.
    - Counter increments while (seg_q, en_q) equals its value on the previous cycle.
    - Any change restarts the counter at 1.
    - When the counter reaches STABLE_CYC, the block captures and moves to HELD.
  - HELD: no further capture until (seg_q, en_q) changes.
    - Change to another one-hot pair → SETTLE, counter = 1.
    - Change to a non-one-hot value → WAIT.
  - In every state, a non-one-hot en_q forces WAIT.
- Capture action:
  - digit[i] ← decode(seg_q) and bad[i] ← decode error, where i is the set bit of en_q.
  - seen[i] ← 1.
  - Recapturing an already-seen digit overwrites it.
- Frame completion: when seen becomes all-ones, on the next edge:
  - out_bcd ← digit and out_err ← |bad.
  - out_valid ← 1.
  - seen ← 0 and bad ← 0.
- Output handshake:
  - out_bcd and out_err are held stable while out_valid && !out_ready.
  - out_valid drops on the edge after acceptance unless a new frame loads on that same edge.
  - A frame completing while out_valid && !out_ready is dropped, overflow ← 1, and seen is cleared.
  - Completion on the same edge as acceptance loads the new frame; out_valid stays 1 and overflow is untouched.
- rst at any time clears the FSM to WAIT, the counter, digit, seen, bad and all outputs; any partial frame is discarded.

## Timing
- Input register adds 1 cycle.
- Capture edge: with STABLE_CYC=N and a pair held from before input edge E0, seg_q/en_q are valid after E0 and capture occurs at edge E(N).
  - digit and seen are visible after E(N).
- Frame output: out_valid rises one edge after the capture that completes seen (edge E(N+1)).
- STABLE_CYC=1: a capture happens on the first edge a new one-hot pair is seen in seg_q/en_q.
- Throughput: at most one capture per cycle, one frame per NDIG captures.
- No combinational path from inputs to outputs; out_ready only affects state at the next edge.

## Structure
- Package sevenseg_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK constants (8-bit);
  - BCD_BLANK (4'hA) and BCD_BAD (4'hF);
  - the FSM state enum (WAIT, SETTLE, HELD).
- Sub-module sevenseg_decode is the combinational seg[7:0] → {bad, bcd[3:0]} lookup; it is shared with future display loopback checks.
- Top holds the input register, stable counter, FSM, digit/seen/bad registers and the output stage.

## Test plan
- NDIG=4, STABLE_CYC=4; drive digits 3,1,4,1 (0xBA,0x28,0x78,0x28), each for 6 cycles → out_valid with out_bcd=16'h1413, out_err=0.
- Digit 0 shows 0xBA for 3 cycles then 0xDA for 4 cycles → only 5 (0xDA) is captured.
- dig_en=4'b0011 for 10 cycles → no capture, FSM stays in WAIT.
- Pattern 0x55 on digit 2 and 0x00 on digit 1 → that nibble = F, nibble 1 = A, out_err=1.
- out_ready=0 across two complete frames → first frame is held unchanged, overflow=1.
  - Then out_ready=1 → out_valid drops the next cycle.
- Assert rst with 3 of 4 digits captured, then send 1 full frame → output matches that frame only; all outputs are 0 during reset.
